// File: rtl/axi_read_responder.sv
// axi_read_responder
//   Responder (slave) end of the ICacheAxi read channel. Accepts one AR request
//   at a time and returns an AXI R burst of (len+1) beats. The beats are read
//   from a synchronous single-port word memory with a one-cycle read latency.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   ar_*            read address channel (valid/ready/id/addr/len/size/burst)
//   r_*             read data channel (valid/ready/id/data/resp/last)
//   mem_en          memory read strobe
//   mem_addr        memory word index
//   mem_rdata       memory read data, valid the cycle after mem_en
//
// Configuration macro
//   AXI_RESP_ERR_EN  when defined, a burst whose start word index lies beyond
//                    MEM_DEPTH, or whose ar_burst is 2'b11, returns SLVERR with
//                    zero data on every beat and never strobes the memory.
//                    When undefined, r_resp is always OKAY, the word index wraps
//                    modulo MEM_DEPTH and burst type 2'b11 behaves as INCR.
module axi_read_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ar_valid,
  output logic                         ar_ready,
  input  logic [ID_WIDTH-1:0]          ar_id,
  input  logic [ADDR_WIDTH-1:0]        ar_addr,
  input  logic [7:0]                   ar_len,
  input  logic [2:0]                   ar_size,
  input  logic [1:0]                   ar_burst,
  output logic                         r_valid,
  input  logic                         r_ready,
  output logic [ID_WIDTH-1:0]          r_id,
  output logic [DATA_WIDTH-1:0]        r_data,
  output logic [1:0]                   r_resp,
  output logic                         r_last,
  output logic                         mem_en,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int unsigned OFFW = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDXW = $clog2(MEM_DEPTH);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  // Latched request
  logic [ID_WIDTH-1:0]   r_id_q;
  addr_t                 r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
`ifdef AXI_RESP_ERR_EN
  logic                  r_err;
`endif

  // Issue / beat counters
  logic [8:0]            r_icnt;
  logic [7:0]            r_bcnt;

  // One read in flight (issued last cycle) plus 2-entry skid buffer
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_wr;
  logic                  r_rd;
  logic [1:0]            r_cnt;

  logic                  w_valid;
  logic                  w_last;
  logic                  w_pop;
  logic                  w_pop_buf;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_in_data;
  logic [2:0]            w_occ;

  addr_t                 w_step;
  addr_t                 w_addr_inc;
  addr_t                 w_wrap_bytes;
  addr_t                 w_wrap_mask;
  addr_t                 w_addr_next;

  // Next beat address: FIXED holds, INCR steps by 2^size, WRAP keeps the
  // upper bits of the (len+1)*2^size aligned window and wraps the low bits.
  always_comb begin
    w_step       = addr_t'(1) << r_size;
    w_addr_inc   = r_addr + w_step;
    w_wrap_bytes = (addr_t'(r_len) + addr_t'(1)) << r_size;
    w_wrap_mask  = w_wrap_bytes - addr_t'(1);
    case (r_burst)
      2'b00:   w_addr_next = r_addr;
      2'b10:   w_addr_next = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
      default: w_addr_next = w_addr_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // The head beat comes straight from the memory output while the skid
  // buffer is empty, giving r_valid two cycles after the AR handshake and
  // one beat per cycle; stalled beats are parked in the buffer.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_occ        = {1'b0, r_cnt} + {2'b00, r_inflight};
    w_valid      = (r_cnt != 2'd0) || r_inflight;
    w_last       = w_valid && (r_bcnt == r_len);
    w_pop        = w_valid && r_ready;
    w_pop_buf    = w_pop && (r_cnt != 2'd0);
    w_push       = r_inflight && !(w_pop && (r_cnt == 2'd0));
    ar_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ar_ready = 1'b1;
        if (ar_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_BURST;
        end
      end
      ST_BURST: begin
        w_issue = (r_icnt <= {1'b0, r_len}) && (w_occ < 3'd2);
        if (w_pop && w_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
`ifdef AXI_RESP_ERR_EN
    w_in_data = r_err ? '0 : mem_rdata;
    mem_en    = w_issue && !r_err;
    r_resp    = (w_valid && r_err) ? 2'b10 : 2'b00;
`else
    w_in_data = mem_rdata;
    mem_en    = w_issue;
    r_resp    = 2'b00;
`endif
    r_valid  = w_valid;
    r_last   = w_last;
    r_id     = r_id_q;
    r_data   = '0;
    if (w_valid) r_data = (r_cnt != 2'd0) ? r_buf[r_rd] : w_in_data;
    mem_addr = r_addr[OFFW +: IDXW];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_q     <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
`ifdef AXI_RESP_ERR_EN
      r_err      <= 1'b0;
`endif
      r_icnt     <= '0;
      r_bcnt     <= '0;
      r_inflight <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_id_q  <= ar_id;
        r_addr  <= ar_addr;
        r_len   <= ar_len;
        r_size  <= ar_size;
        r_burst <= ar_burst;
`ifdef AXI_RESP_ERR_EN
        r_err   <= (ar_burst == 2'b11) || ((ar_addr >> (OFFW + IDXW)) != '0);
`endif
        r_icnt  <= '0;
        r_bcnt  <= '0;
      end
      if (w_issue) begin
        r_addr <= w_addr_next;
        r_icnt <= r_icnt + 9'd1;
      end
      r_inflight <= w_issue;
      if (w_push) begin
        r_buf[r_wr] <= w_in_data;
        r_wr        <= ~r_wr;
      end
      if (w_pop_buf) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop_buf};
      if (w_pop) r_bcnt <= r_bcnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi_read_responder.sv
module tb_axi_read_responder;

  localparam int MEM_DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        ar_valid;
  logic        ar_ready;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid;
  logic        r_ready;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        mem_en;
  logic [11:0] mem_addr;
  logic [63:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mem [MEM_DEPTH];

  axi_read_responder #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(64),
    .ID_WIDTH  (4),
    .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ar_valid (ar_valid),
    .ar_ready (ar_ready),
    .ar_id    (ar_id),
    .ar_addr  (ar_addr),
    .ar_len   (ar_len),
    .ar_size  (ar_size),
    .ar_burst (ar_burst),
    .r_valid  (r_valid),
    .r_ready  (r_ready),
    .r_id     (r_id),
    .r_data   (r_data),
    .r_resp   (r_resp),
    .r_last   (r_last),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory, one-cycle read latency
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  // Byte address of beat i, computed in closed form from the AXI burst rules
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                            input int size, input logic [1:0] burst,
                                            input int i);
    logic [31:0] step, total, base, off;
    step  = 32'd1 << size;
    total = 32'(len + 1) << size;
    case (burst)
      2'b00: return a;
      2'b10: begin
        base = a - (a % total);
        off  = (a - base + 32'(i) * step) % total;
        return base + off;
      end
      default: return a + 32'(i) * step;
    endcase
  endfunction

  function automatic logic [11:0] word_of(input logic [31:0] a);
    return 12'((a >> 3) % MEM_DEPTH);
  endfunction

  function automatic bit is_err(input logic [31:0] a, input logic [1:0] burst);
`ifdef AXI_RESP_ERR_EN
    return (burst == 2'b11) || ((a >> 3) >= MEM_DEPTH);
`else
    return (a != a) && (burst != burst);
`endif
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 always ready, 1 fixed toggle pattern, 2 random
  task automatic run_burst(input string nm, input logic [3:0] id, input logic [31:0] addr,
                           input int len, input int size, input logic [1:0] burst,
                           input int rmode, input bit chk_timing);
    int          beats = 0;
    int          cyc = 0;
    int          first_cyc = -1;
    int          mem_cnt = 0;
    bit          prev_stall = 0;
    bit          err;
    logic [63:0] pdata, exp_d;
    logic        plast;
    logic [1:0]  presp, exp_r;
    int          pat[6] = '{1, 0, 0, 1, 0, 1};
    err   = is_err(addr, burst);
    exp_r = err ? 2'b10 : 2'b00;

    n_checks++;
    if (ar_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ar_ready_idle got %b want 1", nm, ar_ready);
    end
    ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = 8'(len);
    ar_size = 3'(size); ar_burst = burst;
    next_cycle(); cyc = 1;
    ar_valid = 1'b0;

    while (beats < len + 1 && cyc < 300) begin
      case (rmode)
        0:       r_ready = 1'b1;
        1:       r_ready = pat[cyc % 6] != 0;
        default: r_ready = 1'($urandom_range(0, 1));
      endcase
      if (mem_en) begin
        n_checks++;
        if (mem_addr !== word_of(beat_addr(addr, len, size, burst, mem_cnt))) begin
          n_fail++; $display("FAIL %s mem_addr issue %0d got %h want %h", nm, mem_cnt,
                             mem_addr, word_of(beat_addr(addr, len, size, burst, mem_cnt)));
        end
        n_checks++;
        if (mem_cnt - beats >= 2) begin
          n_fail++; $display("FAIL %s skid_overissue outstanding %0d want <2", nm, mem_cnt - beats);
        end
        mem_cnt++;
      end
      if (prev_stall) begin
        n_checks++;
        if (r_valid !== 1'b1 || r_data !== pdata || r_last !== plast || r_resp !== presp) begin
          n_fail++; $display("FAIL %s stall_stable beat %0d got v%b %h l%b r%b want v1 %h l%b r%b",
                             nm, beats, r_valid, r_data, r_last, r_resp, pdata, plast, presp);
        end
      end
      if (r_valid === 1'b1) begin
        if (r_ready) begin
          exp_d = err ? 64'd0 : mem[word_of(beat_addr(addr, len, size, burst, beats))];
          n_checks++;
          if (r_data !== exp_d) begin
            n_fail++; $display("FAIL %s data beat %0d got %h want %h", nm, beats, r_data, exp_d);
          end
          n_checks++;
          if (r_last !== (beats == len)) begin
            n_fail++; $display("FAIL %s last beat %0d got %b want %b", nm, beats, r_last, beats == len);
          end
          n_checks++;
          if (r_id !== id || r_resp !== exp_r) begin
            n_fail++; $display("FAIL %s id_resp beat %0d got %h/%b want %h/%b",
                               nm, beats, r_id, r_resp, id, exp_r);
          end
          if (first_cyc < 0) first_cyc = cyc;
          beats++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          pdata = r_data; plast = r_last; presp = r_resp;
        end
      end else begin
        prev_stall = 0;
      end
      next_cycle(); cyc++;
    end

    n_checks++;
    if (beats != len + 1) begin
      n_fail++; $display("FAIL %s beat_count got %0d want %0d (timeout)", nm, beats, len + 1);
    end
    n_checks++;
    if (mem_cnt != (err ? 0 : len + 1)) begin
      n_fail++; $display("FAIL %s mem_en_count got %0d want %0d", nm, mem_cnt, err ? 0 : len + 1);
    end
    n_checks++;
    if (ar_ready !== 1'b1 || r_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s after_burst got ar_ready %b r_valid %b want 1 0", nm, ar_ready, r_valid);
    end
    if (chk_timing) begin
      n_checks++;
      if (first_cyc != 2 || cyc != len + 3) begin
        n_fail++; $display("FAIL %s timing first %0d end %0d want 2 %0d", nm, first_cyc, cyc, len + 3);
      end
    end
    r_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; ar_valid = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0;
    ar_size = '0; ar_burst = '0; r_ready = 1'b0;
    next_cycle(); next_cycle();
    n_checks++;
    if (ar_ready !== 1'b1 || r_valid !== 1'b0 || r_last !== 1'b0 || r_resp !== 2'b00 ||
        r_id !== 4'h0 || r_data !== 64'd0 || mem_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_values got ar_ready %b r_valid %b r_last %b r_resp %b r_id %h r_data %h mem_en %b",
                         ar_ready, r_valid, r_last, r_resp, r_id, r_data, mem_en);
    end
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_incr;
    run_burst("incr", 4'h5, 32'h100, 3, 3, 2'b01, 0, 1);
  endtask

  task automatic test_wrap;
    run_burst("wrap", 4'ha, 32'h118, 3, 3, 2'b10, 0, 1);
  endtask

  task automatic test_backpressure;
    run_burst("bp", 4'h3, 32'h100, 3, 3, 2'b01, 1, 0);
  endtask

  task automatic test_back_to_back;
    logic [63:0] ea, eb;
    ea = mem[12'h040];
    eb = mem[12'h07f];
    r_ready = 1'b1;
    ar_valid = 1'b1; ar_id = 4'h1; ar_addr = 32'h200; ar_len = 8'd0; ar_size = 3'd3; ar_burst = 2'b00;
    n_checks++;
    if (ar_ready !== 1'b1) begin n_fail++; $display("FAIL b2b ar_ready_c0 got %b want 1", ar_ready); end
    next_cycle();
    ar_id = 4'h2; ar_addr = 32'h3f8;
    n_checks++;
    if (ar_ready !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 12'h040) begin
      n_fail++; $display("FAIL b2b c1 got ar_ready %b mem_en %b mem_addr %h want 0 1 040", ar_ready, mem_en, mem_addr);
    end
    next_cycle();
    n_checks++;
    if (ar_ready !== 1'b0 || r_valid !== 1'b1 || r_data !== ea || r_last !== 1'b1 || r_id !== 4'h1) begin
      n_fail++; $display("FAIL b2b beatA got ar_ready %b v %b %h l %b id %h want 0 1 %h 1 1",
                         ar_ready, r_valid, r_data, r_last, r_id, ea);
    end
    next_cycle();
    n_checks++;
    if (ar_ready !== 1'b1 || r_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b c3 got ar_ready %b r_valid %b want 1 0", ar_ready, r_valid);
    end
    next_cycle();
    ar_valid = 1'b0;
    n_checks++;
    if (mem_en !== 1'b1 || mem_addr !== 12'h07f) begin
      n_fail++; $display("FAIL b2b c4 got mem_en %b mem_addr %h want 1 07f", mem_en, mem_addr);
    end
    next_cycle();
    n_checks++;
    if (r_valid !== 1'b1 || r_data !== eb || r_last !== 1'b1 || r_id !== 4'h2) begin
      n_fail++; $display("FAIL b2b beatB got v %b %h l %b id %h want 1 %h 1 2", r_valid, r_data, r_last, r_id, eb);
    end
    next_cycle();
    r_ready = 1'b0;
  endtask

  task automatic test_reset_mid_burst;
    r_ready = 1'b1;
    ar_valid = 1'b1; ar_id = 4'h7; ar_addr = 32'h400; ar_len = 8'd7; ar_size = 3'd3; ar_burst = 2'b01;
    next_cycle();
    ar_valid = 1'b0;
    next_cycle(); next_cycle(); next_cycle();
    n_checks++;
    if (r_valid !== 1'b1 || r_data !== mem[12'h082]) begin
      n_fail++; $display("FAIL midrst beat2 got v %b %h want 1 %h", r_valid, r_data, mem[12'h082]);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (r_valid !== 1'b0 || ar_ready !== 1'b1 || mem_en !== 1'b0 || r_last !== 1'b0 ||
        r_data !== 64'd0 || r_id !== 4'h0) begin
      n_fail++; $display("FAIL midrst outputs got v %b ar_ready %b mem_en %b l %b %h id %h want 0 1 0 0 0 0",
                         r_valid, ar_ready, mem_en, r_last, r_data, r_id);
    end
    next_cycle();
    rst = 1'b1;
    r_ready = 1'b0;
    next_cycle();
    run_burst("after_rst", 4'h9, 32'h400, 7, 3, 2'b01, 0, 1);
  endtask

  task automatic test_out_of_range;
    run_burst("oor", 4'hc, 32'(MEM_DEPTH * 8), 1, 3, 2'b01, 0, 1);
  endtask

  task automatic test_random;
    int lens[4] = '{1, 3, 7, 15};
    for (int k = 0; k < 16; k++) begin
      logic [1:0]  b;
      int          sz, ln, md;
      logic [31:0] a;
      b  = 2'($urandom_range(0, 3));
      sz = $urandom_range(0, 3);
      ln = (b == 2'b10) ? lens[$urandom_range(0, 3)] : $urandom_range(0, 15);
      a  = 32'($urandom_range(0, 32'h6fff)) & ~((32'd1 << sz) - 32'd1);
      md = ($urandom_range(0, 1) != 0) ? 2 : 0;
      run_burst($sformatf("rand%0d", k), 4'($urandom), a, ln, sz, b, md, md == 0);
      repeat ($urandom_range(0, 2)) next_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = {$urandom, $urandom};
    mem_rdata = '0;
    test_reset();
    test_incr();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
    test_out_of_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
